// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word memory between fetch (I) and load/store (D).
// One access in flight; word-aligns, range-checks and merges partial stores by read-modify-write.
module mem_arbiter #(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, RMW_RD, RMW_WR, ERR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;          // 1: D has priority on contention
    logic        own_q;               // 1: access belongs to D
    logic        err_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;

    logic        grant;
    logic        sel_d;
    logic [31:0] sel_addr;
    logic        sel_bad;
    logic [31:0] merged;

    // Winner selection for the IDLE cycle
    assign sel_d    = d_req && (!i_req || rr_q);
    assign grant    = (state_q == IDLE) && !reset && (i_req || d_req);
    assign sel_addr = sel_d ? d_addr : i_addr;
    assign sel_bad  = ({2'b00, sel_addr[31:2]} >= 32'(MEM_SIZE)) ||
                      (sel_d && (sel_addr[1:0] != 2'b00));

    // Next state and grants
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    i_gnt = !sel_d;
                    d_gnt = sel_d;
                    rr_d  = !sel_d;
                    if (sel_bad)
                        state_d = ERR;
                    else if (sel_d && d_we) begin
                        // An empty store passes through ERR so it answers with the usual two-cycle latency
                        if (d_be == 4'b0000)
                            state_d = ERR;
                        else if (d_be == 4'b1111)
                            state_d = WRITE;
                        else
                            state_d = RMW_RD;
                    end else
                        state_d = READ;
                end
            end
            READ, WRITE, RMW_WR, ERR: state_d = RESP;
            RMW_RD:                   state_d = RMW_WR;
            RESP:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Partial-store merge: old word is in read format (byte k at [31-8k -: 8])
    always_comb begin
        merged = 32'h0;
        for (int k = 0; k < 4; k++)
            merged[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : old_q[8*(3-k) +: 8];
    end

    assign mem_we = !reset && ((state_q == WRITE) || (state_q == RMW_WR));

    always_comb begin
        mem_wd = 32'h0;
        if (state_q == WRITE)
            mem_wd = wdata_q;
        else if (state_q == RMW_WR)
            mem_wd = merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            own_q    <= 1'b0;
            err_q    <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            old_q    <= 32'h0;
            mem_a    <= 32'h0;
            i_rdata  <= 32'h0;
            d_rdata  <= 32'h0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (grant) begin
                own_q   <= sel_d;
                err_q   <= sel_bad;
                be_q    <= d_be;
                wdata_q <= d_wdata;
                mem_a   <= {sel_addr[31:2], 2'b00};
            end
            if (state_q == READ) begin
                if (own_q)
                    d_rdata <= mem_rd;
                else
                    i_rdata <= mem_rd;
            end
            if (state_q == RMW_RD)
                old_q <= mem_rd;
            // Response strobes line up with the RESP state
            i_rvalid <= (state_d == RESP) && !own_q;
            d_rvalid <= (state_d == RESP) && own_q;
            i_err    <= (state_d == RESP) && !own_q && err_q;
            d_err    <= (state_d == RESP) && own_q && err_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus
// contention, reset-during-write and reset-state sequences.
module tb_mem_arbiter;

    localparam int unsigned MEM_SIZE = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_rvalid, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:MEM_SIZE-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Memory model: reads return byte a at [31:24], writes take byte a from [7:0]
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign mem_rd = mem[mem_a[13:2]];
    always @(posedge clk)
        if (mem_we) mem[mem_a[13:2]] <= bswap(mem_wd);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;     // number of mem_we cycles
        int          exp_wecyc;  // cycle after grant of the write
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [12];

    task automatic drive_idle();
        i_req = 0; d_req = 0; d_we = 0; d_be = 4'h0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    // One access from a free IDLE cycle; checks grant, latency, response and memory traffic
    task automatic run(input int idx, input vec_t v);
        int w, lat, we_cnt, we_cyc;
        logic got_err, wrong_side;
        logic [31:0] wd, rd;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1; i_addr = v.addr;
        end
        #1;
        for (w = 0; w < 10 && !(v.is_d ? d_gnt : i_gnt); w++) begin
            @(posedge clk); #2;
        end
        chk($sformatf("v%0d gnt_wait", idx), 32'(w), 32'd0);
        chk($sformatf("v%0d other_gnt", idx), 32'(v.is_d ? i_gnt : d_gnt), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        lat = 0; we_cnt = 0; we_cyc = 0; wd = 32'h0; rd = 32'h0;
        got_err = 0; wrong_side = 0;
        for (int c = 1; c <= 6; c++) begin
            if (mem_we) begin we_cnt++; we_cyc = c; wd = mem_wd; end
            if (v.is_d ? i_rvalid : d_rvalid) wrong_side = 1;
            if (v.is_d ? d_rvalid : i_rvalid) begin
                lat = c;
                got_err = v.is_d ? d_err : i_err;
                rd = v.is_d ? d_rdata : i_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d err", idx), 32'(got_err), 32'(v.exp_err));
        chk($sformatf("v%0d wrong_rvalid", idx), 32'(wrong_side), 32'd0);
        chk($sformatf("v%0d we_count", idx), 32'(we_cnt), 32'(v.exp_we));
        if (v.exp_we != 0) begin
            chk($sformatf("v%0d we_cycle", idx), 32'(we_cyc), 32'(v.exp_wecyc));
            chk($sformatf("v%0d mem_wd", idx), wd, v.exp_wd);
        end
        if (v.chk_rd)
            chk($sformatf("v%0d rdata", idx), rd, v.exp_rd);
    endtask

    initial begin
        int seq[$];
        int cyc, overlap;
        logic busy, saw_rvalid;

        //          is_d we be    addr          wdata         chk rd  exp_rd        err lat we cyc wd
        vecs[0]  = '{1'b0, 0, 4'h0, 32'h0000_0004, 32'h0,         1, 32'h2001_0113, 0, 2, 0, 0, 32'h0};
        vecs[1]  = '{1'b0, 0, 4'h0, 32'h0000_0007, 32'h0,         1, 32'h2001_0113, 0, 2, 0, 0, 32'h0};
        vecs[2]  = '{1'b1, 0, 4'h0, 32'h0000_0200, 32'h0,         1, 32'hCAFE_F00D, 0, 2, 0, 0, 32'h0};
        vecs[3]  = '{1'b1, 1, 4'h2, 32'h0000_0100, 32'h0000_AA00, 0, 32'h0,         0, 3, 1, 2, 32'h4433_AA11};
        vecs[4]  = '{1'b1, 0, 4'h0, 32'h0000_0100, 32'h0,         1, 32'h11AA_3344, 0, 2, 0, 0, 32'h0};
        vecs[5]  = '{1'b1, 0, 4'h0, 32'h0000_0102, 32'h0,         0, 32'h0,         1, 2, 0, 0, 32'h0};
        vecs[6]  = '{1'b0, 0, 4'h0, 32'h0000_4000, 32'h0,         0, 32'h0,         1, 2, 0, 0, 32'h0};
        vecs[7]  = '{1'b1, 1, 4'hF, 32'h0000_0200, 32'h1234_5678, 0, 32'h0,         0, 2, 1, 1, 32'h1234_5678};
        vecs[8]  = '{1'b1, 0, 4'h0, 32'h0000_0200, 32'h0,         1, 32'h7856_3412, 0, 2, 0, 0, 32'h0};
        vecs[9]  = '{1'b1, 1, 4'h0, 32'h0000_0104, 32'hFFFF_FFFF, 0, 32'h0,         0, 2, 0, 0, 32'h0};
        vecs[10] = '{1'b1, 0, 4'h0, 32'h0000_3FFC, 32'h0,         1, 32'hDEAD_BEEF, 0, 2, 0, 0, 32'h0};
        vecs[11] = '{1'b1, 1, 4'hF, 32'h0000_4000, 32'h5A5A_5A5A, 0, 32'h0,         1, 2, 0, 0, 32'h0};

        for (int k = 0; k < int'(MEM_SIZE); k++) mem[k] = 32'(k) ^ 32'hA5A5_0000;
        mem[1]    = 32'h2001_0113;
        mem[16'h40] = 32'h1122_3344;
        mem[16'h41] = 32'h0BAD_0104;
        mem[16'h42] = 32'h0BAD_F00D;
        mem[16'h80] = 32'hCAFE_F00D;
        mem[MEM_SIZE-1] = 32'hDEAD_BEEF;

        // Reset state, with a request pending that must not be granted
        drive_idle();
        reset = 1; i_req = 1; i_addr = 32'h4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst i_gnt", 32'(i_gnt), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        chk("rst err", {30'd0, i_err, d_err}, 32'd0);
        chk("rst i_rdata", i_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        drive_idle();
        reset = 0;

        for (int n = 0; n < 12; n++) run(n, vecs[n]);
        chk("be0 memory untouched", mem[16'h41], 32'h0BAD_0104);
        chk("bad store memory untouched", mem[0], 32'hA5A5_0000);

        // Contention after reset: both held, expect I,D,I,D with no overlap
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        i_req = 1; i_addr = 32'h4;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        busy = 0; overlap = 0;
        for (cyc = 0; cyc < 60 && seq.size() < 4; cyc++) begin
            #1;
            if (i_rvalid || d_rvalid) busy = 0;
            if (i_gnt && d_gnt) overlap++;
            if (i_gnt || d_gnt) begin
                if (busy) overlap++;
                busy = 1;
                seq.push_back(d_gnt ? 1 : 0);
            end
            @(posedge clk); #1;
        end
        drive_idle();
        chk("contention grants", 32'(seq.size()), 32'd4);
        for (int g = 0; g < 4 && g < seq.size(); g++)
            chk($sformatf("contention order %0d", g), 32'(seq[g]), 32'(g % 2));
        chk("contention overlap", 32'(overlap), 32'd0);
        repeat (4) @(posedge clk);

        // Reset during the WRITE cycle of a full store
        #1;
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h108; d_wdata = 32'h5555_5555;
        #1;
        chk("rstw d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        reset = 1;
        #1;
        chk("rstw mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        saw_rvalid = 0;
        for (int c = 0; c < 4; c++) begin
            if (d_rvalid || i_rvalid) saw_rvalid = 1;
            @(posedge clk); #1;
        end
        chk("rstw no rvalid", 32'(saw_rvalid), 32'd0);
        chk("rstw memory", mem[16'h42], 32'h0BAD_F00D);
        run(100, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
